sr04_echo_emulator: RTL and testbench

Emulates an HC-SR04 ultrasonic sensor, acting as the responder end of the trig/echo protocol that the distance-measurement controller drives.
- Watches the incoming trig line and qualifies pulses of at least 10 us.
- After a fixed burst delay, drives an echo pulse whose width encodes a programmed distance (58 us per cm).
- Used on the board loopback and in benches to exercise the measurement path without a physical sensor.

---
 rtl/sr04_echo_emulator_if.sv | 33 +++
 rtl/sr04_echo_emulator.sv | 101 ++++++++++
 tb/tb_sr04_echo_emulator.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr04_echo_emulator_if.sv
// Trig/echo link between a distance-measurement controller (master) and the
// emulated HC-SR04 responder (slave).
interface sr04_echo_emulator_if;
    logic       trig;
    logic [8:0] i_dist_cm;
    logic       echo;
    logic       o_busy;
    logic       o_short_trig;
    logic [7:0] o_resp_cnt;
    logic [2:0] dbg_state;

    // Not a valid/ready link: trig is a level pulse qualified by its width,
    // i_dist_cm is sampled once per accepted request, echo is the reply.
    modport master (
        output trig,
        output i_dist_cm,
        input  echo,
        input  o_busy,
        input  o_short_trig,
        input  o_resp_cnt,
        input  dbg_state
    );

    modport slave (
        input  trig,
        input  i_dist_cm,
        output echo,
        output o_busy,
        output o_short_trig,
        output o_resp_cnt,
        output dbg_state
    );
endinterface

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder. If the first clk edge that samples raw trig low is edge j,
// echo rises on edge j + 2 + BURST_US*TICK_DIV and stays high for W*TICK_DIV clk.
module sr04_echo_emulator #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input logic                clk,
    input logic                rst,
    sr04_echo_emulator_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / 1_000_000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG_HI = 3'd1;
    localparam logic [2:0] BURST   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    logic [2:0]       state, state_next;
    logic             trig_s1, trig_s2, trig_d;
    logic             trig_rise, trig_fall;
    logic [PRE_W-1:0] pre;
    logic             pre_wrap;
    logic [15:0]      us_cnt, us_inc, us_now;
    logic             trig_ok;
    logic [8:0]       dist_q;
    logic [15:0]      echo_w;
    logic             echo_q, short_q;
    logic [7:0]       resp_q;

    assign trig_rise = trig_s2 & ~trig_d;
    assign trig_fall = ~trig_s2 & trig_d;

    // us_now counts the current clk, so a request lasting exactly N us
    // qualifies on the clk that completes its N-th microsecond.
    assign pre_wrap = (pre == PRE_W'(TICK_DIV - 1));
    assign us_inc   = (us_cnt == 16'hFFFF) ? us_cnt : us_cnt + 16'd1;
    assign us_now   = pre_wrap ? us_inc : us_cnt;
    assign trig_ok  = (us_now >= 16'(TRIG_MIN_US));

    assign echo_w = (dist_q >= 9'd2 && 32'(dist_q) <= MAX_CM)
                    ? 16'(dist_q) * 16'(US_PER_CM)
                    : 16'(TIMEOUT_US);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig_rise) state_next = TRIG_HI;
            TRIG_HI: if (trig_fall) state_next = trig_ok ? BURST : IDLE;
            BURST:   if (us_now >= 16'(BURST_US)) state_next = ECHO;
            ECHO:    if (us_now >= echo_w) state_next = HOLDOFF;
            HOLDOFF: if (us_now >= 16'(HOLDOFF_US)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
            state   <= IDLE;
            pre     <= '0;
            us_cnt  <= '0;
            dist_q  <= '0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            trig_s1 <= bus.trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
            state   <= state_next;

            if (state_next != state || pre_wrap) pre <= '0;
            else                                 pre <= pre + PRE_W'(1);

            if (state_next != state) us_cnt <= '0;
            else if (pre_wrap)       us_cnt <= us_inc;

            if (state == TRIG_HI && trig_fall && trig_ok) dist_q <= bus.i_dist_cm;

            echo_q  <= (state_next == ECHO);
            short_q <= (state == TRIG_HI) && trig_fall && !trig_ok;

            if (state == ECHO && state_next == HOLDOFF) resp_q <= resp_q + 8'd1;
        end
    end

    assign bus.echo         = echo_q;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_short_trig = short_q;
    assign bus.o_resp_cnt   = resp_q;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Bench for sr04_echo_emulator: a default-timing instance and a fast instance
// (short burst/timeout/holdoff) run side by side against a timeline model.
module tb_sr04_echo_emulator;
    localparam int INF = 32'h7fff_ffff;
    localparam int TRIG_MIN_CLK = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r   [2];
    logic       trig_r  [2];
    logic [8:0] dist_r  [2];
    logic       echo_v  [2];
    logic       busy_v  [2];
    logic       short_v [2];
    logic [7:0] resp_v  [2];

    int p_burst [2] = '{200, 20};
    int p_to    [2] = '{38000, 40};
    int p_ho    [2] = '{10000, 10};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    sr04_echo_emulator_if a_if ();
    sr04_echo_emulator_if b_if ();

    assign a_if.trig = trig_r[0];
    assign a_if.i_dist_cm = dist_r[0];
    assign b_if.trig = trig_r[1];
    assign b_if.i_dist_cm = dist_r[1];
    assign echo_v[0] = a_if.echo;
    assign echo_v[1] = b_if.echo;
    assign busy_v[0] = a_if.o_busy;
    assign busy_v[1] = b_if.o_busy;
    assign short_v[0] = a_if.o_short_trig;
    assign short_v[1] = b_if.o_short_trig;
    assign resp_v[0] = a_if.o_resp_cnt;
    assign resp_v[1] = b_if.o_resp_cnt;

    sr04_echo_emulator #(.CLK_HZ(1_000_000)) dut_a (
        .clk (clk),
        .rst (rst_r[0]),
        .bus (a_if)
    );

    sr04_echo_emulator #(
        .CLK_HZ     (1_000_000),
        .BURST_US   (20),
        .TIMEOUT_US (40),
        .HOLDOFF_US (10)
    ) dut_b (
        .clk (clk),
        .rst (rst_r[1]),
        .bus (b_if)
    );

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d required=%0d", name, i, cyc, act, exp);
        end
    endtask

    // Expected behaviour as a timeline: each accepted request yields windows
    // [busy_from, busy_to) and [echo_rise, echo_fall) in clk-edge numbers.
    int m_prev [2], m_pend [2], m_rise [2], m_free [2];
    int m_er [2], m_ef [2], m_bf [2], m_bt [2], m_sh [2], m_resp [2];

    function automatic int echo_width(input int i, input int d);
        if (d >= 2 && d <= 400) return d * 58;
        return p_to[i];
    endfunction

    function automatic void model_clear(input int i);
        m_prev[i] = 0;  m_pend[i] = 0; m_rise[i] = 0; m_free[i] = 0;
        m_er[i]   = -1; m_ef[i]   = -1; m_bf[i] = -1; m_bt[i]   = -1;
        m_sh[i]   = -1; m_resp[i] = 0;
    endfunction

    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!rst_r[i]) begin
                    model_clear(i);
                end else begin
                    if (cyc == m_ef[i]) m_resp[i] = (m_resp[i] + 1) % 256;
                    if (trig_r[i] && m_prev[i] == 0 && m_pend[i] == 0 && cyc + 1 >= m_free[i]) begin
                        m_pend[i] = 1;
                        m_rise[i] = cyc;
                        m_bf[i]   = cyc + 2;
                        m_bt[i]   = INF;
                    end else if (!trig_r[i] && m_prev[i] != 0 && m_pend[i] != 0) begin
                        m_pend[i] = 0;
                        if (cyc - m_rise[i] >= TRIG_MIN_CLK) begin
                            m_er[i] = cyc + 2 + p_burst[i];
                            m_ef[i] = m_er[i] + echo_width(i, int'(dist_r[i]));
                            m_bt[i] = m_ef[i] + p_ho[i];
                        end else begin
                            m_bt[i] = cyc + 2;
                            m_sh[i] = cyc + 2;
                        end
                        m_free[i] = m_bt[i];
                    end
                    m_prev[i] = trig_r[i] ? 1 : 0;
                end
            end
        end
    end

    initial begin
        logic e_echo, e_busy, e_short;
        logic [7:0] e_resp;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                e_echo  = rst_r[i] && cyc >= m_er[i] && cyc < m_ef[i];
                e_busy  = rst_r[i] && cyc >= m_bf[i] && cyc < m_bt[i];
                e_short = rst_r[i] && cyc == m_sh[i];
                e_resp  = rst_r[i] ? 8'(m_resp[i]) : 8'd0;
                check("echo", i, 32'(echo_v[i]), 32'(e_echo));
                check("busy", i, 32'(busy_v[i]), 32'(e_busy));
                check("short", i, 32'(short_v[i]), 32'(e_short));
                check("resp", i, 32'(resp_v[i]), 32'(e_resp));
            end
        end
    end

    task automatic pulse_trig(input int i, input int h);
        @(negedge clk);
        trig_r[i] = 1'b1;
        repeat (h) @(negedge clk);
        trig_r[i] = 1'b0;
    endtask

    task automatic wait_rise(input int i, input int budget, output int rc);
        rc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (echo_v[i]) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL echo_rise_timeout dut%0d cyc=%0d actual=no_rise required=rise", i, cyc);
        end
    endtask

    task automatic measure_high(input int i, input int budget, output int w);
        w = 0;
        while (echo_v[i] && w < budget) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic run_a();
        int rc, w, fall, n_sh, n_ec;
        dist_r[0] = 9'd10;
        pulse_trig(0, 12);
        fall = cyc + 1;
        wait_rise(0, 400, rc);
        check("latency", 0, 32'(rc - fall), 32'd202);
        measure_high(0, 1000, w);
        check("width_10cm", 0, 32'(w), 32'd580);
        check("resp_first", 0, 32'(resp_v[0]), 32'd1);
        repeat (9999) @(negedge clk);
        check("busy_in_holdoff", 0, 32'(busy_v[0]), 32'd1);
        @(negedge clk);
        check("busy_after_holdoff", 0, 32'(busy_v[0]), 32'd0);

        pulse_trig(0, 5);
        n_sh = 0;
        n_ec = 0;
        repeat (1000) begin
            @(negedge clk);
            if (short_v[0]) n_sh++;
            if (echo_v[0]) n_ec++;
        end
        check("short_pulses", 0, 32'(n_sh), 32'd1);
        check("short_no_echo", 0, 32'(n_ec), 32'd0);
        check("short_busy", 0, 32'(busy_v[0]), 32'd0);

        dist_r[0] = 9'd10;
        pulse_trig(0, 12);
        wait_rise(0, 400, rc);
        repeat (100) @(negedge clk);
        dist_r[0] = 9'd300;
        measure_high(0, 1000, w);
        check("latched_width", 0, 32'(w), 32'd480);
        repeat (1000) @(negedge clk);
        pulse_trig(0, 20);
        n_ec = 0;
        repeat (10000) begin
            @(negedge clk);
            if (echo_v[0]) n_ec++;
        end
        check("holdoff_trig_ignored", 0, 32'(n_ec), 32'd0);
        check("holdoff_idle", 0, 32'(busy_v[0]), 32'd0);

        dist_r[0] = 9'd10;
        pulse_trig(0, 12);
        wait_rise(0, 400, rc);
        repeat (300) @(negedge clk);
        rst_r[0] = 1'b0;
        #1;
        check("rst_echo", 0, 32'(echo_v[0]), 32'd0);
        check("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        check("rst_resp", 0, 32'(resp_v[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_r[0] = 1'b1;
        repeat (5) @(negedge clk);
        pulse_trig(0, 12);
        wait_rise(0, 400, rc);
        measure_high(0, 1000, w);
        check("post_rst_width", 0, 32'(w), 32'd580);
        check("post_rst_resp", 0, 32'(resp_v[0]), 32'd1);
    endtask

    task automatic run_b();
        int dl [5] = '{401, 0, 400, 2, 1};
        int wl [5] = '{40, 40, 23200, 116, 40};
        int rc, w, fall, n_sh, n_ec;
        for (int k = 0; k < 5; k++) begin
            dist_r[1] = 9'(dl[k]);
            pulse_trig(1, 12);
            fall = cyc + 1;
            wait_rise(1, 24000, rc);
            if (k == 0) check("latency_fast", 1, 32'(rc - fall), 32'd22);
            measure_high(1, 24000, w);
            check("width_dist", 1, 32'(w), 32'(wl[k]));
            repeat (20) @(negedge clk);
        end

        dist_r[1] = 9'd3;
        pulse_trig(1, 10);
        wait_rise(1, 100, rc);
        measure_high(1, 400, w);
        check("trig_10us_width", 1, 32'(w), 32'd174);
        repeat (20) @(negedge clk);

        pulse_trig(1, 9);
        n_sh = 0;
        n_ec = 0;
        repeat (60) begin
            @(negedge clk);
            if (short_v[1]) n_sh++;
            if (echo_v[1]) n_ec++;
        end
        check("trig_9us_short", 1, 32'(n_sh), 32'd1);
        check("trig_9us_no_echo", 1, 32'(n_ec), 32'd0);

        dist_r[1] = 9'd5;
        pulse_trig(1, 12);
        wait_rise(1, 100, rc);
        trig_r[1] = 1'b1;
        measure_high(1, 400, w);
        check("held_trig_width", 1, 32'(w), 32'd290);
        repeat (40) @(negedge clk);
        trig_r[1] = 1'b0;
        n_ec = 0;
        repeat (100) begin
            @(negedge clk);
            if (echo_v[1]) n_ec++;
        end
        check("held_trig_no_restart", 1, 32'(n_ec), 32'd0);
        check("held_trig_idle", 1, 32'(busy_v[1]), 32'd0);
        check("resp_seven", 1, 32'(resp_v[1]), 32'd7);

        @(negedge clk);
        rst_r[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_r[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("resp_cleared", 1, 32'(resp_v[1]), 32'd0);

        dist_r[1] = 9'd0;
        for (int k = 0; k < 256; k++) begin
            pulse_trig(1, 12);
            wait_rise(1, 100, rc);
            measure_high(1, 100, w);
            if (k == 254) check("resp_255", 1, 32'(resp_v[1]), 32'd255);
            repeat (12) @(negedge clk);
        end
        check("resp_wrap", 1, 32'(resp_v[1]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_r[i]  = 1'b0;
            trig_r[i] = 1'b0;
            dist_r[i] = 9'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_echo", i, 32'(echo_v[i]), 32'd0);
            check("reset_busy", i, 32'(busy_v[i]), 32'd0);
            check("reset_short", i, 32'(short_v[i]), 32'd0);
            check("reset_resp", i, 32'(resp_v[i]), 32'd0);
        end
        rst_r[0] = 1'b1;
        rst_r[1] = 1'b1;
        repeat (3) @(negedge clk);
        fork
            run_a();
            run_b();
        join
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
